// File: rtl/rect_pkg.sv
// Shared types and constants for the rectangle rasteriser.
`timescale 1ns/1ps
package rect_pkg;

    // Draw mode encodings as presented on the mode input.
    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    // Default visible screen size (VGA adapter at 160x120).
    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;

    // Top-level control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Row-major position counter for the rectangle rasteriser. Holds ix/iy,
// applies the outline-mode jump across interior rows and flags the final
// position. Exposes the next-cycle position so the parent can register
// its pixel outputs one cycle ahead.
`timescale 1ns/1ps
module raster_counter
    import rect_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          adv,
    input  logic          outline,
    input  logic [SW-1:0] w,
    input  logic [SW-1:0] h,
    output logic [SW-1:0] ix_nxt,
    output logic [SW-1:0] iy_nxt,
    output logic          last
);

    logic [SW-1:0] ix_q, ix_d;
    logic [SW-1:0] iy_q, iy_d;

    // Next position: clear to origin, or step ix with row wrap and outline jump.
    always_comb begin
        ix_d = ix_q;
        iy_d = iy_q;
        if (clear) begin
            ix_d = '0;
            iy_d = '0;
        end else if (adv) begin
            if (ix_q == w) begin
                ix_d = '0;
                iy_d = iy_q + SW'(1);
            end else if (outline && (ix_q == '0) && (iy_q != '0) && (iy_q != h)) begin
                // Interior rows of an outline only visit the two edge columns.
                ix_d = w;
            end else begin
                ix_d = ix_q + SW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ix_q <= '0;
            iy_q <= '0;
        end else begin
            ix_q <= ix_d;
            iy_q <= iy_d;
        end
    end

    assign ix_nxt = ix_d;
    assign iy_nxt = iy_d;
    assign last   = (ix_q == w) && (iy_q == h);

endmodule

// File: rtl/rect_raster.sv
// Rectangle rasteriser: captures a rectangle on start, walks its positions
// one per cycle, clips against the screen and streams visible pixels to the
// VGA plot port under a plot/ready handshake. All outputs are registered;
// the pixel for the upcoming position is computed from next-state values.
`timescale 1ns/1ps
module rect_raster
    import rect_pkg::*;
#(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int SW    = 4,
    parameter int COLW  = 3,
    parameter int SCR_W = SCR_W_DEF,
    parameter int SCR_H = SCR_H_DEF
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [XW-1:0]   x0,
    input  logic [YW-1:0]   y0,
    input  logic [SW-1:0]   w,
    input  logic [SW-1:0]   h,
    input  logic [COLW-1:0] colour_in,
    input  logic            mode,
    input  logic            ready,
    output logic            plot,
    output logic [XW-1:0]   out_x,
    output logic [YW-1:0]   out_y,
    output logic [COLW-1:0] out_colour,
    output logic            busy,
    output logic            done
);

    state_e state_q, state_d;

    // Captured draw parameters.
    logic [XW-1:0]   x0_q, x0_d;
    logic [YW-1:0]   y0_q, y0_d;
    logic [SW-1:0]   w_q, w_d;
    logic [SW-1:0]   h_q, h_d;
    logic [COLW-1:0] col_q, col_d;
    logic            mode_q, mode_d;

    // Registered outputs.
    logic            plot_q, plot_d;
    logic [XW-1:0]   out_x_q, out_x_d;
    logic [YW-1:0]   out_y_q, out_y_d;
    logic [COLW-1:0] out_col_q, out_col_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            take;
    logic            consume;
    logic            adv;
    logic            last;
    logic [SW-1:0]   ix_nxt, iy_nxt;
    logic [XW:0]     px_d;
    logic [YW:0]     py_d;
    logic            clip_d;

    // A start is only honoured from IDLE; a position is consumed when it is
    // either clipped (no plot presented) or the sink accepts it.
    assign take    = (state_q == IDLE) && start;
    assign consume = (state_q == RUN) && (!plot_q || ready);
    assign adv     = consume && !last;

    raster_counter #(
        .SW (SW)
    ) u_counter (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (take),
        .adv     (adv),
        .outline (mode_q == MODE_OUTLINE),
        .w       (w_q),
        .h       (h_q),
        .ix_nxt  (ix_nxt),
        .iy_nxt  (iy_nxt),
        .last    (last)
    );

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (consume && last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the rectangle description on an accepted start only.
    always_comb begin
        x0_d   = x0_q;
        y0_d   = y0_q;
        w_d    = w_q;
        h_d    = h_q;
        col_d  = col_q;
        mode_d = mode_q;
        if (take) begin
            x0_d   = x0;
            y0_d   = y0;
            w_d    = w;
            h_d    = h;
            col_d  = colour_in;
            mode_d = mode;
        end
    end

    // Pixel for the next cycle's position, widened by one bit so an origin
    // near the edge cannot wrap back onto the screen.
    always_comb begin
        px_d      = {1'b0, x0_d} + (XW+1)'(ix_nxt);
        py_d      = {1'b0, y0_d} + (YW+1)'(iy_nxt);
        clip_d    = (px_d >= (XW+1)'(SCR_W)) || (py_d >= (YW+1)'(SCR_H));
        plot_d    = 1'b0;
        out_x_d   = '0;
        out_y_d   = '0;
        out_col_d = '0;
        busy_d    = (state_d == RUN);
        done_d    = (state_d == DONE);
        if ((state_d == RUN) && !clip_d) begin
            plot_d    = 1'b1;
            out_x_d   = px_d[XW-1:0];
            out_y_d   = py_d[YW-1:0];
            out_col_d = col_d;
        end
    end

    // Control state and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            plot_q    <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_col_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            plot_q    <= plot_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            out_col_q <= out_col_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Draw parameter registers; only meaningful after a capture.
    always_ff @(posedge clk) begin
        x0_q   <= x0_d;
        y0_q   <= y0_d;
        w_q    <= w_d;
        h_q    <= h_d;
        col_q  <= col_d;
        mode_q <= mode_d;
    end

    assign plot       = plot_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_col_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/rect_raster.md
# rect_raster

Parametrised rectangle rasteriser for the paint datapath. On a start pulse it captures an origin, extent, colour and mode, then steps through the rectangle one pixel position per cycle and emits on-screen pixel coordinates to the VGA plot interface under a valid/ready handshake. It supports filled and outline modes, clips against the screen bounds, and pulses `done` on completion. It sits between the paint control FSM and the VGA adapter write port.

## Interface
Parameters:
- `XW`, 8: x coordinate width.
- `YW`, 7: y coordinate width.
- `SW`, 4: extent field width.
- `COLW`, 3: colour width.
- `SCR_W`, 160: visible columns. Valid x is 0..SCR_W-1.
- `SCR_H`, 120: visible rows. Valid y is 0..SCR_H-1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a draw. Sampled only in IDLE.
- `x0`, input, XW: origin x, top-left corner.
- `y0`, input, YW: origin y.
- `w`, input, SW: extent; the rectangle spans w+1 columns.
- `h`, input, SW: extent; the rectangle spans h+1 rows.
- `colour_in`, input, COLW: pixel colour.
- `mode`, input, 1: 0 = fill, 1 = outline.
- `ready`, input, 1: sink accepts the current pixel.
- `plot`, output, 1: `out_x`/`out_y`/`out_colour` are valid.
- `out_x`, output, XW: pixel x.
- `out_y`, output, YW: pixel y.
- `out_colour`, output, COLW: pixel colour.
- `busy`, output, 1: a draw is in progress (RUN state).
- `done`, output, 1: one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: if `start`, capture x0/y0/w/h/colour_in/mode into registers, clear ix=iy=0, and go to RUN.
  - RUN: process the position (ix, iy) defined below.
  - DONE: assert `done` for one cycle, then go to IDLE. `start` is ignored in DONE.
- Raster order: row-major, iy outer, ix inner, both ascending from 0.
- Position arithmetic: px = x0_r + ix and py = y0_r + iy are computed at XW+1 and YW+1 bits, so no wrap-around.
- A position is clipped when px ≥ SCR_W or py ≥ SCR_H.
- Outline mode: on rows 0 < iy < h, ix jumps from 0 directly to w. Interior positions are never visited. Rows 0 and h are fully traversed. If w = 0 the jump is a no-op, and column 0 is visited once per row.
- Per RUN position:
  - Unclipped: `plot` = 1, outputs = px/py truncated to XW/YW, plus colour. Hold until `ready`=1, then advance on that edge.
  - Clipped: `plot` = 0; advance after one cycle.
- Advance: step ix; at the row end, set ix=0 and step iy. After the last position (ix=w, iy=h) is consumed, go to DONE.
- `start` while busy is ignored; captured registers do not change mid-draw.
- Outputs are driven from registers only. `plot` has no combinational dependence on `ready`.
- Outside RUN, `plot`=0 and `out_x`/`out_y`/`out_colour` = 0.

## Timing
- Reset values: `plot`=0, `busy`=0, `done`=0, `out_x`=0, `out_y`=0, `out_colour`=0; state is IDLE.
- Reset is asynchronous: asserting `resetn` low mid-draw forces all of the above immediately. The draw is abandoned with no `done`.
- Latency: `start` is sampled at edge 0. The first position appears in cycle 1 with `busy`=1.
- Fill, no clipping, `ready` held high: N=(w+1)(h+1) plot cycles in cycles 1..N, then `done` in cycle N+1 with `busy`=0. IDLE is re-entered in cycle N+2.
- Outline, no clipping: position count is 2(w+1) + 2(h-1) for h ≥ 1 and w ≥ 1; it is w+1 for h=0.
- Each low cycle of `ready` on a visible pixel adds one cycle. Outputs stay stable throughout the stall.

## Structure
- Package `rect_pkg` holds:
  - `MODE_FILL`/`MODE_OUTLINE` encodings.
  - State enum `IDLE/RUN/DONE`.
  - Default SCR_W/SCR_H constants.
- One sub-module is natural: `raster_counter`.
  - Holds ix/iy, the advance enable, and the outline jump.
  - Flags the last position.
  - Parametrised by SW.
- Clipping, the handshake and the FSM stay in `rect_raster`.

## Test plan
- Fill, x0=10, y0=20, w=1, h=1, colour=5, `ready`=1: plots (10,20), (11,20), (10,21), (11,21) in cycles 1–4; `done` in cycle 5.
- Outline, x0=0, y0=0, w=3, h=2: exactly 10 plots. Row 1 yields only (0,1) and (3,1). `done` is the cycle after the last handshake.
- Backpressure, fill 2×1 (w=1, h=0): hold `ready` low for 3 cycles on the first pixel. Required: `plot` and (x0,y0) held stable, no advance, `done` 3 cycles later than the unstalled case.
- Clipping, x0=158, y0=119, w=3, h=1: only (158,119) and (159,119) plotted. Cycles: 2 plots + 6 skips, `done` in cycle 9. Also x0=200, w=0, h=0: no `plot`, `done` in cycle 2.
- `start` pulsed again mid-draw: ignored, pixel stream unchanged. `start` in the DONE cycle: ignored.
- `resetn` low during RUN: `plot`/`busy`/outputs go to 0 asynchronously and no `done` is issued. A subsequent start of w=0, h=0 plots one pixel, with `done` in cycle 2.
